// File: rtl/mplier_pkg.sv
// Constants and types shared across the multiplier datapath.
// The multiplier top reuses this package when it inserts its pipeline registers.
package mplier_pkg;
    localparam int PROD_W  = 64;
    localparam int SPLIT_W = 32;
    localparam int TAG_W   = 4;

    typedef struct packed {
        logic [PROD_W-1:0] sums;
        logic [PROD_W-1:0] couts;
    } cs_pair_t;
endpackage

// File: rtl/cpa_slice.sv
// N-bit carry-propagate adder slice with carry-in and carry-out.
module cpa_slice #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, cin_i};
endmodule

// File: rtl/csa_resolve64.sv
// Two-stage split carry-propagate add that collapses a carry-save pair into the product,
// with valid/ready handshakes on both sides and a tag carried in order.
module csa_resolve64
    import mplier_pkg::*;
#(
    parameter int WIDTH = PROD_W,
    parameter int SPLIT = SPLIT_W,
    parameter int TAG_W = mplier_pkg::TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sums,
    input  logic [WIDTH-1:0] couts,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product,
    output logic [TAG_W-1:0] out_tag
);
    localparam int HW = WIDTH - SPLIT;

    logic [WIDTH-1:0] c_eff;
    logic [SPLIT-1:0] lo_sum;
    logic             lo_cout;
    logic [HW-1:0]    hi_sum;
    logic             hi_cout;
    logic             s1_load, s2_load;

    logic             s1_valid_q,   s1_valid_d;
    logic [SPLIT-1:0] s1_lo_q,      s1_lo_d;
    logic             s1_carry_q,   s1_carry_d;
    logic [HW-1:0]    s1_sums_hi_q, s1_sums_hi_d;
    logic [HW-1:0]    s1_c_hi_q,    s1_c_hi_d;
    logic [TAG_W-1:0] s1_tag_q,     s1_tag_d;
    logic             out_valid_q,  out_valid_d;
    logic [WIDTH-1:0] product_q,    product_d;
    logic [TAG_W-1:0] out_tag_q,    out_tag_d;

    // couts carries weight 2^(i+1); its top bit falls off the end of the product.
    assign c_eff = {couts[WIDTH-2:0], 1'b0};

    logic unused_bits;
    assign unused_bits = ^{couts[WIDTH-1], hi_cout};

    cpa_slice #(.N(SPLIT)) u_lo (
        .a_i   (sums[SPLIT-1:0]),
        .b_i   (c_eff[SPLIT-1:0]),
        .cin_i (1'b0),
        .sum_o (lo_sum),
        .cout_o(lo_cout)
    );

    cpa_slice #(.N(HW)) u_hi (
        .a_i   (s1_sums_hi_q),
        .b_i   (s1_c_hi_q),
        .cin_i (s1_carry_q),
        .sum_o (hi_sum),
        .cout_o(hi_cout)
    );

    assign in_ready = !s1_valid_q || !out_valid_q || out_ready;
    assign s1_load  = in_valid && in_ready;
    assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);

    always_comb begin
        s1_lo_d      = s1_lo_q;
        s1_carry_d   = s1_carry_q;
        s1_sums_hi_d = s1_sums_hi_q;
        s1_c_hi_d    = s1_c_hi_q;
        s1_tag_d     = s1_tag_q;
        product_d    = product_q;
        out_tag_d    = out_tag_q;
        s1_valid_d   = s1_load || (s1_valid_q && !s2_load);
        out_valid_d  = s2_load || (out_valid_q && !out_ready);
        if (s1_load) begin
            s1_lo_d      = lo_sum;
            s1_carry_d   = lo_cout;
            s1_sums_hi_d = sums[WIDTH-1:SPLIT];
            s1_c_hi_d    = c_eff[WIDTH-1:SPLIT];
            s1_tag_d     = in_tag;
        end
        if (s2_load) begin
            product_d = {hi_sum, s1_lo_q};
            out_tag_d = s1_tag_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_lo_q      <= '0;
            s1_carry_q   <= 1'b0;
            s1_sums_hi_q <= '0;
            s1_c_hi_q    <= '0;
            s1_tag_q     <= '0;
            out_valid_q  <= 1'b0;
            product_q    <= '0;
            out_tag_q    <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_lo_q      <= s1_lo_d;
            s1_carry_q   <= s1_carry_d;
            s1_sums_hi_q <= s1_sums_hi_d;
            s1_c_hi_q    <= s1_c_hi_d;
            s1_tag_q     <= s1_tag_d;
            out_valid_q  <= out_valid_d;
            product_q    <= product_d;
            out_tag_q    <= out_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign out_tag   = out_tag_q;
endmodule

// File: tb/tb_csa_resolve64.sv
// Bench for csa_resolve64: a two-deep in-order queue model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_csa_resolve64;
    import mplier_pkg::*;

    logic              clk, rst, in_valid, in_ready, out_valid, out_ready;
    logic [PROD_W-1:0] sums, couts, product;
    logic [3:0]        in_tag, out_tag;

    csa_resolve64 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sums(sums), .couts(couts), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .product(product), .out_tag(out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: ops in flight, oldest first, each with the number of edges since accept.
    typedef struct {
        logic [63:0] prod;
        logic [3:0]  tag;
        int          age;
    } ent_t;
    ent_t        mq[$];
    logic [63:0] pop_prod[$];
    logic [3:0]  pop_tag[$];
    int          pop_cyc[$];
    int          acc_cyc[$];
    int          cyc = 0;
    int          vcnt = 0;
    int          stall_cnt = 0;
    bit          prev_rst = 1'b1;

    always @(negedge clk) begin
        bit   exp_ov, exp_rdy;
        ent_t e;
        cyc++;
        exp_ov  = (mq.size() > 0) && (mq[0].age >= 1);
        exp_rdy = (mq.size() < 2) || out_ready;
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (prev_rst) begin
            chk("rst_product", product, 64'd0);
            chk("rst_tag", 64'(out_tag), 64'd0);
        end
        if (exp_ov && out_valid) begin
            chk("product", product, mq[0].prod);
            chk("out_tag", 64'(out_tag), 64'(mq[0].tag));
        end
        if (out_valid) vcnt++;
        if (in_valid && !in_ready) stall_cnt++;
        if (rst) begin
            mq.delete();
            prev_rst = 1'b1;
        end else begin
            prev_rst = 1'b0;
            if (exp_ov && out_ready) begin
                pop_prod.push_back(product);
                pop_tag.push_back(out_tag);
                pop_cyc.push_back(cyc);
                void'(mq.pop_front());
            end
            foreach (mq[i]) mq[i].age++;
            if (in_valid && exp_rdy) begin
                e.prod = sums + (couts << 1);
                e.tag  = in_tag;
                e.age  = 0;
                mq.push_back(e);
                acc_cyc.push_back(cyc);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [63:0] s, input logic [63:0] c, input logic [3:0] t);
        bit done = 1'b0;
        bit acc;
        sums = s; couts = c; in_tag = t; in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) done = 1'b1;
        end
        if (!done) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic pop_chk(input string nm, input int idx, input logic [63:0] p, input logic [3:0] t);
        if (idx < pop_prod.size()) begin
            chk({nm, "_prod"}, pop_prod[idx], p);
            chk({nm, "_tag"}, 64'(pop_tag[idx]), 64'(t));
        end else begin
            chk({nm, "_missing"}, 64'd0, 64'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          p0, a0, v0, s0;
        logic [63:0] refp[8];
        cs_pair_t    cs;
        longint      ra, rb;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        sums = '0; couts = '0; in_tag = '0;
        step(2);
        rst = 1'b0;
        step(1);

        // Basic add: 5 + (3 << 1) = 11
        p0 = pop_prod.size(); a0 = acc_cyc.size(); v0 = vcnt;
        send(64'd5, 64'd3, 4'hA);
        in_valid = 1'b0;
        step(5);
        pop_chk("basic", p0, 64'd11, 4'hA);
        chk("basic_valid_cycles", 64'(vcnt - v0), 64'd1);
        if (p0 < pop_cyc.size() && a0 < acc_cyc.size())
            chk("basic_latency", 64'(pop_cyc[p0] - acc_cyc[a0]), 64'd2);
        else
            chk("basic_latency_missing", 64'd0, 64'd1);

        // Carry crosses the split point
        p0 = pop_prod.size();
        send(64'h0000_0000_FFFF_FFFF, 64'h1, 4'h3);
        in_valid = 1'b0;
        step(4);
        pop_chk("split", p0, 64'h0000_0001_0000_0001, 4'h3);

        // Wrap and discard of couts[63]
        p0 = pop_prod.size();
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 4'h5);
        in_valid = 1'b0;
        step(4);
        pop_chk("wrap", p0, 64'h0000_0000_0000_0001, 4'h5);

        // Backpressure: sums=16k+1, couts=k -> 18k+1
        p0 = pop_prod.size(); s0 = stall_cnt;
        out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 4; k++) send(64'(16 * k + 1), 64'(k), 4'(k));
                in_valid = 1'b0;
            end
            begin
                step(4);
                out_ready = 1'b1;
            end
        join
        step(6);
        pop_chk("bp0", p0,     64'd1,  4'd0);
        pop_chk("bp1", p0 + 1, 64'd19, 4'd1);
        pop_chk("bp2", p0 + 2, 64'd37, 4'd2);
        pop_chk("bp3", p0 + 3, 64'd55, 4'd3);
        chk("bp_stall_cycles", 64'(stall_cnt - s0), 64'd2);

        // Streaming signed 32x32 products in random carry-save form
        p0 = pop_prod.size(); a0 = acc_cyc.size();
        for (int k = 0; k < 8; k++) begin
            ra = longint'(int'($urandom));
            rb = longint'(int'($urandom));
            refp[k]  = 64'(ra * rb);
            cs.couts = {$urandom, $urandom};
            cs.sums  = refp[k] - (cs.couts << 1);
            send(cs.sums, cs.couts, 4'(k + 4));
        end
        in_valid = 1'b0;
        step(6);
        for (int k = 0; k < 8; k++) pop_chk($sformatf("stream%0d", k), p0 + k, refp[k], 4'(k + 4));
        if (p0 + 7 < pop_cyc.size() && a0 < acc_cyc.size()) begin
            chk("stream_first_latency", 64'(pop_cyc[p0] - acc_cyc[a0]), 64'd2);
            chk("stream_back_to_back", 64'(pop_cyc[p0 + 7] - pop_cyc[p0]), 64'd7);
        end else begin
            chk("stream_timing_missing", 64'd0, 64'd1);
        end

        // Reset with both stages full and a new op presented in the reset cycle
        out_ready = 1'b0;
        send(64'd7, 64'd1, 4'h1);
        send(64'd9, 64'd2, 4'h2);
        sums = 64'd100; couts = 64'd100; in_tag = 4'hF; in_valid = 1'b1;
        rst = 1'b1;
        step(1);
        rst = 1'b0; in_valid = 1'b0;
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        chk("post_rst_product", product, 64'd0);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        p0 = pop_prod.size();
        out_ready = 1'b1;
        step(6);
        chk("post_rst_no_stale", 64'(pop_prod.size()), 64'(p0));

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
